// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALU op codes,
// FSM state encoding and instruction field positions.
package controle_multiciclo_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORI  = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_EXEC   = 3'd2;
  localparam state_t S_WB     = 3'd3;
  localparam state_t S_HALT   = 3'd4;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;
  localparam int unsigned RD_HI  = 11;
  localparam int unsigned RD_LO  = 10;
  localparam int unsigned RS_HI  = 9;
  localparam int unsigned RS_LO  = 8;
  localparam int unsigned IMM_HI = 7;
  localparam int unsigned IMM_LO = 0;

  // R-type instructions take their second register operand from imm[1:0].
  function automatic logic is_rtype(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/controle_multiciclo_decod.sv
// Purely combinational opcode decoder: ALU operation, operand source and
// instruction-class flags for the control FSM.
module decodificador_instr
  import controle_multiciclo_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] alu_op,
  output logic       alu_src_imm,
  output logic       writes_reg,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case, so no path can infer a latch.
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    writes_reg  = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    is_halt     = 1'b0;
    is_illegal  = 1'b0;
    case (opcode)
      OP_ADD:  begin alu_op = ALU_ADD; writes_reg = 1'b1; end
      OP_ADDI: begin alu_op = ALU_ADD; alu_src_imm = 1'b1; writes_reg = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; writes_reg = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; writes_reg = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; alu_src_imm = 1'b1; writes_reg = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  writes_reg = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_src_imm = 1'b1; writes_reg = 1'b1; end
      OP_BEQ:  begin alu_op = ALU_SUB; is_branch = 1'b1; end
      OP_JMP:  is_jump = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC/WB sequencing, PC update and ALU
// control. Define ILLEGAL_TRAP_EN to trap illegal opcodes into HALT.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic [7:0]  pc,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  input  logic        zero,
  output logic [1:0]  rs_sel,
  output logic [1:0]  rt_sel,
  output logic [1:0]  rd_sel,
  output logic [7:0]  imm,
  output logic        reg_write,
  output logic        halted,
  output logic        illegal
);

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [7:0]  ir_imm;
  logic [1:0]  dec_alu_op;
  logic        dec_src_imm, dec_writes_reg, dec_branch, dec_jump, dec_halt, dec_illegal;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign ir_imm = ir[IMM_HI:IMM_LO];

  decodificador_instr u_decod (
    .opcode      (opcode),
    .alu_op      (dec_alu_op),
    .alu_src_imm (dec_src_imm),
    .writes_reg  (dec_writes_reg),
    .is_branch   (dec_branch),
    .is_jump     (dec_jump),
    .is_halt     (dec_halt),
    .is_illegal  (dec_illegal)
  );

  // NOTE: IR is a plain data register; every output that reads it is masked in
  // FETCH/HALT, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == S_FETCH && instr_valid) ir <= instr;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= '0;
    end else begin
      case (state)
        S_FETCH: if (instr_valid) state <= S_DECODE;
        S_DECODE: begin
          if (dec_jump) begin
            pc    <= ir_imm;
            state <= S_FETCH;
          end else if (dec_halt) begin
            state <= S_HALT;
          end else if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            state <= S_HALT;
`else
            pc    <= pc + 8'd1;
            state <= S_FETCH;
`endif
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (dec_branch) begin
            // Branch offset is relative to the following instruction.
            pc    <= zero ? (pc + 8'd1 + ir_imm) : (pc + 8'd1);
            state <= S_FETCH;
          end else begin
            state <= S_WB;
          end
        end
        S_WB: begin
          pc    <= pc + 8'd1;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                  illegal_q <= 1'b0;
    else if (state == S_DECODE && dec_illegal)   illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    instr_req   = (state == S_FETCH);
    halted      = (state == S_HALT);
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    rs_sel      = '0;
    rt_sel      = '0;
    rd_sel      = '0;
    imm         = '0;
    if (state == S_DECODE || state == S_EXEC || state == S_WB) begin
      rs_sel = ir[RS_HI:RS_LO];
      rd_sel = ir[RD_HI:RD_LO];
      imm    = ir_imm;
      if (is_rtype(opcode))  rt_sel = ir_imm[1:0];
      else if (dec_branch)   rt_sel = ir[RD_HI:RD_LO];
    end
    // ALU controls stay stable from EXEC through WB while the result is written.
    if (state == S_EXEC || state == S_WB) begin
      alu_op      = dec_alu_op;
      alu_src_imm = dec_src_imm;
    end
    reg_write = (state == S_WB) && dec_writes_reg;
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: per-instruction schedule model
// compared every cycle, plus hand-computed literal checks.
module tb_controle_multiciclo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic        instr_valid;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [1:0]  alu_op;
  logic        alu_src_imm;
  logic        zero;
  logic [1:0]  rs_sel, rt_sel, rd_sel;
  logic [7:0]  imm;
  logic        reg_write;
  logic        halted;
  logic        illegal;

  controle_multiciclo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_req   (instr_req),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .zero        (zero),
    .rs_sel      (rs_sel),
    .rt_sel      (rt_sel),
    .rd_sel      (rd_sel),
    .imm         (imm),
    .reg_write   (reg_write),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected DUT outputs for one cycle.
  typedef struct {
    bit       req;
    bit       halted;
    bit       illegal;
    bit       rw;
    bit       chk_alu;
    bit [1:0] alu_op;
    bit       src;
    bit [1:0] rs;
    bit [1:0] rd;
    bit [1:0] rt;
    bit       chk_rt;
    bit [7:0] imm;
    bit [7:0] pc;
  } exp_t;

  exp_t     cur;
  exp_t     sched[$];
  bit [7:0] m_pc;
  bit       m_halted, m_illegal;
  bit       model_ok = 1'b0;

  function automatic exp_t idle_rec(input bit [7:0] p, input bit h, input bit il);
    exp_t r;
    r = '{default: 0};
    r.req     = !h;
    r.halted  = h;
    r.illegal = il;
    r.chk_alu = 1'b1;
    r.chk_rt  = 1'b1;
    r.pc      = p;
    return r;
  endfunction

  // Expand one accepted instruction into the cycles it occupies before FETCH.
  task automatic build_schedule(input logic [15:0] w, input logic z);
    bit [3:0] op;
    exp_t     d, e, wb;
    op = w[15:12];
    d = idle_rec(m_pc, 1'b0, m_illegal);
    d.req = 1'b0; d.chk_alu = 1'b0;
    d.rd = w[11:10]; d.rs = w[9:8]; d.imm = w[7:0];
    if (op == 4'h0 || op == 4'h2 || op == 4'h3 || op == 4'h5) d.rt = w[1:0];
    else if (op == 4'h7) d.rt = w[11:10];
    else d.chk_rt = 1'b0;
    e = d; e.chk_alu = 1'b1;
    if (op <= 4'h6) begin
      case (op)
        4'h0, 4'h1: e.alu_op = 2'b00;
        4'h2:       e.alu_op = 2'b01;
        4'h3, 4'h4: e.alu_op = 2'b10;
        default:    e.alu_op = 2'b11;
      endcase
      e.src = (op == 4'h1 || op == 4'h4 || op == 4'h6);
      wb = e; wb.rw = 1'b1;
      sched.push_back(d); sched.push_back(e); sched.push_back(wb);
      m_pc = m_pc + 8'd1;
    end else if (op == 4'h7) begin
      e.alu_op = 2'b01;
      sched.push_back(d); sched.push_back(e);
      m_pc = z ? (m_pc + 8'd1 + w[7:0]) : (m_pc + 8'd1);
    end else if (op == 4'h8) begin
      sched.push_back(d);
      m_pc = w[7:0];
    end else if (op == 4'hF) begin
      sched.push_back(d);
      m_halted = 1'b1;
    end else begin
      sched.push_back(d);
`ifdef ILLEGAL_TRAP_EN
      m_halted  = 1'b1;
      m_illegal = 1'b1;
`else
      m_pc = m_pc + 8'd1;
`endif
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 8'h00; m_halted = 1'b0; m_illegal = 1'b0;
      sched.delete();
      cur = idle_rec(8'h00, 1'b0, 1'b0);
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (sched.size() != 0) cur = sched.pop_front();
      else if (cur.req && instr_valid) begin
        build_schedule(instr, zero);
        cur = sched.pop_front();
      end else cur = idle_rec(m_pc, m_halted, m_illegal);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("m_pc", pc, cur.pc);
      check("m_instr_req", instr_req, cur.req);
      check("m_halted", halted, cur.halted);
      check("m_illegal", illegal, cur.illegal);
      check("m_reg_write", reg_write, cur.rw);
      check("m_rs_sel", rs_sel, cur.rs);
      check("m_rd_sel", rd_sel, cur.rd);
      check("m_imm", imm, cur.imm);
      if (cur.chk_rt) check("m_rt_sel", rt_sel, cur.rt);
      if (cur.chk_alu) begin
        check("m_alu_op", alu_op, cur.alu_op);
        check("m_alu_src_imm", alu_src_imm, cur.src);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] w, input int delay, input logic z);
    zero = z;
    instr_valid = 1'b0;
    repeat (delay) step();
    instr = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr = 16'h0000;
  endtask

  task automatic wait_fetch(input string name);
    for (int i = 0; i < 8 && instr_req !== 1'b1; i++) step();
    check(name, instr_req, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; zero = 1'b0;
    repeat (2) step();
    check("rst_pc", pc, 8'h00);
    check("rst_req", instr_req, 1'b1);
    check("rst_rw", reg_write, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_alu_op", alu_op, 2'b00);
    rst_n = 1'b1;

    // ADD r1 = r2 + r3
    issue(16'h0603, 0, 1'b0);
    step();
    check("add_alu_op", alu_op, 2'b00);
    check("add_src", alu_src_imm, 1'b0);
    check("add_rs", rs_sel, 2'd2);
    check("add_rt", rt_sel, 2'd3);
    step();
    check("add_rw", reg_write, 1'b1);
    check("add_rd", rd_sel, 2'd1);
    step();
    check("add_pc", pc, 8'h01);

    // ADDI r0 = r1 + 5, valid delayed 3 cycles
    issue(16'h1105, 3, 1'b0);
    step();
    check("addi_src", alu_src_imm, 1'b1);
    check("addi_imm", imm, 8'h05);
    step();
    check("addi_rw", reg_write, 1'b1);
    check("addi_rd", rd_sel, 2'd0);
    wait_fetch("addi_fetch");
    check("addi_pc", pc, 8'h02);

    issue(16'h3A01, 0, 1'b0);  // AND r2 = r2 & r1
    wait_fetch("and_fetch");
    check("and_pc", pc, 8'h03);

    issue(16'h7604, 0, 1'b1);  // BEQ taken
    wait_fetch("beq1_fetch");
    check("beq_taken_pc", pc, 8'h08);

    issue(16'h8003, 0, 1'b0);
    wait_fetch("jmp3_fetch");
    issue(16'h7604, 0, 1'b0);  // BEQ not taken
    wait_fetch("beq2_fetch");
    check("beq_not_taken_pc", pc, 8'h04);

    issue(16'h8003, 0, 1'b0);
    wait_fetch("jmp3b_fetch");
    issue(16'h76FE, 0, 1'b1);  // BEQ backwards
    wait_fetch("beq3_fetch");
    check("beq_back_pc", pc, 8'h02);

    issue(16'h5E02, 0, 1'b0);  // OR r3 = r2 | r2
    wait_fetch("or_fetch");
    issue(16'h6BFF, 0, 1'b0);  // ORI r2 = r3 | FF
    wait_fetch("ori_fetch");
    check("ori_pc", pc, 8'h04);

    issue(16'h8080, 0, 1'b0);  // JMP 80
    step();
    check("jmp_pc", pc, 8'h80);
    check("jmp_req", instr_req, 1'b1);

    issue(16'hC000, 0, 1'b0);  // illegal opcode
    step();
`ifdef ILLEGAL_TRAP_EN
    check("ill_illegal", illegal, 1'b1);
    check("ill_halted", halted, 1'b1);
`else
    check("ill_pc", pc, 8'h81);
    check("ill_illegal", illegal, 1'b0);
    check("ill_rw", reg_write, 1'b0);
`endif
    do_reset();

    issue(16'h80FF, 0, 1'b0);
    wait_fetch("jmpff_fetch");
    issue(16'h0603, 0, 1'b0);
    wait_fetch("wrap_fetch");
    check("pc_wrap", pc, 8'h00);

    issue(16'hF000, 0, 1'b0);  // HALT, with a fetch offered that must be ignored
    instr = 16'h0603;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_halted", halted, 1'b1);
      check("halt_req", instr_req, 1'b0);
    end
    do_reset();
    check("halt_rst_pc", pc, 8'h00);
    check("halt_rst_req", instr_req, 1'b1);
    check("halt_rst_halted", halted, 1'b0);

    issue(16'h0603, 0, 1'b0);
    wait_fetch("pre_sub_fetch");
    issue(16'h2603, 0, 1'b0);  // SUB, reset lands in WB
    step();
    check("sub_alu_op", alu_op, 2'b01);
    step();
    check("sub_wb_rw", reg_write, 1'b1);
    rst_n = 1'b0;
    step();
    check("sub_rst_rw", reg_write, 1'b0);
    check("sub_rst_pc", pc, 8'h00);
    check("sub_rst_alu_op", alu_op, 2'b00);
    check("sub_rst_req", instr_req, 1'b1);
    rst_n = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
